// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: opcodes, ALU op classes and the decoded control bundle.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_BR   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_write_en;
    logic       alu_src;
    logic       mem_to_reg_en;
    logic       mem_read_en;
    logic       mem_write_en;
  } ctrl_t;

  // All-zero bundle: no register write, no memory access, ADD class.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: decodes which source operands the ID instruction reads and
// compares them against a pending load destination in EX.
module hazard_detect
  import rv_pkg::*;
#(
  parameter int unsigned REGW = 5
) (
  input  logic            id_valid_i,
  input  logic [6:0]      id_opcode_i,
  input  logic [REGW-1:0] id_rs1_i,
  input  logic [REGW-1:0] id_rs2_i,
  input  logic            ex_valid_i,
  input  logic            ex_mem_read_en_i,
  input  logic [REGW-1:0] ex_rd_i,
  input  logic            flush_i,
  output logic            hazard_stall_c_o
);

  logic uses_rs1;
  logic uses_rs2;
  logic rs1_hit;
  logic rs2_hit;

  // Operand-use decode; opcodes not listed read no registers.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_opcode_i)
      OP_R, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_I, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign rs1_hit = uses_rs1 && (id_rs1_i == ex_rd_i);
  assign rs2_hit = uses_rs2 && (id_rs2_i == ex_rd_i);

  // x0 is never a real dependency; a flush kills the consumer so no stall is needed.
  assign hazard_stall_c_o = id_valid_i && ex_valid_i && ex_mem_read_en_i &&
                            (ex_rd_i != '0) && (rs1_hit || rs2_hit) && !flush_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and downstream hold.
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5,
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [6:0]      id_opcode,
  input  logic [1:0]      id_alu_op,
  input  logic            id_reg_write_en,
  input  logic            id_alu_src,
  input  logic            id_mem_to_reg_en,
  input  logic            id_mem_read_en,
  input  logic            id_mem_write_en,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_b5,
  input  logic            flush,
  input  logic            ex_hold,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic [1:0]      ex_alu_op,
  output logic            ex_reg_write_en,
  output logic            ex_alu_src,
  output logic            ex_mem_to_reg_en,
  output logic            ex_mem_read_en,
  output logic            ex_mem_write_en,
  output logic [REGW-1:0] ex_rs1,
  output logic [REGW-1:0] ex_rs2,
  output logic [REGW-1:0] ex_rd,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7_b5,
  output logic [CNTW-1:0] bubble_count
);

  ctrl_t           id_ctrl;
  ctrl_t           ctrl_q, ctrl_d;
  logic            valid_q, valid_d;
  logic [REGW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d, pc_q, pc_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            funct7_b5_q, funct7_b5_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  assign id_ctrl = '{alu_op:        id_alu_op,
                     reg_write_en:  id_reg_write_en,
                     alu_src:       id_alu_src,
                     mem_to_reg_en: id_mem_to_reg_en,
                     mem_read_en:   id_mem_read_en,
                     mem_write_en:  id_mem_write_en};

  hazard_detect #(.REGW(REGW)) u_hazard_detect (
    .id_valid_i       (id_valid),
    .id_opcode_i      (id_opcode),
    .id_rs1_i         (id_rs1),
    .id_rs2_i         (id_rs2),
    .ex_valid_i       (valid_q),
    .ex_mem_read_en_i (ctrl_q.mem_read_en),
    .ex_rd_i          (rd_q),
    .flush_i          (flush),
    .hazard_stall_c_o (hazard_stall)
  );

  // Next-state: hold > flush/stall bubble > capture.
  always_comb begin
    ctrl_d      = ctrl_q;
    valid_d     = valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    funct3_d    = funct3_q;
    funct7_b5_d = funct7_b5_q;
    cnt_d       = cnt_q;
    if (!ex_hold) begin
      if (flush || hazard_stall) begin
        ctrl_d      = CTRL_NOP;
        valid_d     = 1'b0;
        rs1_d       = '0;
        rs2_d       = '0;
        rd_d        = '0;
        rs1_data_d  = '0;
        rs2_data_d  = '0;
        imm_d       = '0;
        pc_d        = '0;
        funct3_d    = '0;
        funct7_b5_d = 1'b0;
        if (hazard_stall) cnt_d = cnt_q + CNTW'(1);
      end else begin
        // An empty slot carries no side effects even if the control inputs are stale.
        ctrl_d      = id_valid ? id_ctrl : CTRL_NOP;
        valid_d     = id_valid;
        rs1_d       = id_rs1;
        rs2_d       = id_rs2;
        rd_d        = id_rd;
        rs1_data_d  = id_rs1_data;
        rs2_data_d  = id_rs2_data;
        imm_d       = id_imm;
        pc_d        = id_pc;
        funct3_d    = id_funct3;
        funct7_b5_d = id_funct7_b5;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= CTRL_NOP;
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      funct3_q    <= '0;
      funct7_b5_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      funct3_q    <= funct3_d;
      funct7_b5_q <= funct7_b5_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ex_valid         = valid_q;
  assign ex_alu_op        = ctrl_q.alu_op;
  assign ex_reg_write_en  = ctrl_q.reg_write_en;
  assign ex_alu_src       = ctrl_q.alu_src;
  assign ex_mem_to_reg_en = ctrl_q.mem_to_reg_en;
  assign ex_mem_read_en   = ctrl_q.mem_read_en;
  assign ex_mem_write_en  = ctrl_q.mem_write_en;
  assign ex_rs1           = rs1_q;
  assign ex_rs2           = rs2_q;
  assign ex_rd            = rd_q;
  assign ex_rs1_data      = rs1_data_q;
  assign ex_rs2_data      = rs2_data_q;
  assign ex_imm           = imm_q;
  assign ex_pc            = pc_q;
  assign ex_funct3        = funct3_q;
  assign ex_funct7_b5     = funct7_b5_q;
  assign bubble_count     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use/flush/hold scenarios then random traffic,
// all checked every cycle against a behavioural model of the EX slot.
module tb_id_ex_stage;

  typedef struct {
    logic        valid;
    logic [6:0]  op;
    logic [1:0]  alu_op;
    logic        rw, asrc, m2r, mr, mw;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic [2:0]  f3;
    logic        f7;
  } in_t;

  typedef struct {
    logic        valid;
    logic [1:0]  alu_op;
    logic        rw, asrc, m2r, mr, mw;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] cnt;
  } ex_t;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JR = 7'b1100111, LUI = 7'b0110111, JAL = 7'b1101111;

  logic clk = 1'b0;
  logic reset, flush, ex_hold;
  in_t  cur;
  ex_t  m, nxt;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic        hazard_stall, ex_valid, ex_reg_write_en, ex_alu_src, ex_mem_to_reg_en;
  logic        ex_mem_read_en, ex_mem_write_en, ex_funct7_b5;
  logic [1:0]  ex_alu_op;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, bubble_count;
  logic [2:0]  ex_funct3;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(cur.valid), .id_opcode(cur.op),
    .id_alu_op(cur.alu_op), .id_reg_write_en(cur.rw), .id_alu_src(cur.asrc),
    .id_mem_to_reg_en(cur.m2r), .id_mem_read_en(cur.mr), .id_mem_write_en(cur.mw),
    .id_rs1(cur.rs1), .id_rs2(cur.rs2), .id_rd(cur.rd),
    .id_rs1_data(cur.d1), .id_rs2_data(cur.d2), .id_imm(cur.imm), .id_pc(cur.pc),
    .id_funct3(cur.f3), .id_funct7_b5(cur.f7), .flush(flush), .ex_hold(ex_hold),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_reg_write_en(ex_reg_write_en), .ex_alu_src(ex_alu_src),
    .ex_mem_to_reg_en(ex_mem_to_reg_en), .ex_mem_read_en(ex_mem_read_en),
    .ex_mem_write_en(ex_mem_write_en), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_funct3(ex_funct3), .ex_funct7_b5(ex_funct7_b5), .bubble_count(bubble_count)
  );

  // Build a valid instruction of the given class with its control bundle and random data.
  function automatic in_t mk(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    in_t c;
    c = '{valid: 1'b1, op: op, rd: rd, rs1: rs1, rs2: rs2, alu_op: 2'b00, default: '0};
    c.d1 = $urandom; c.d2 = $urandom; c.imm = $urandom; c.pc = $urandom;
    c.f3 = 3'($urandom_range(0, 7)); c.f7 = 1'($urandom_range(0, 1));
    case (op)
      R:   begin c.alu_op = 2'b10; c.rw = 1'b1; end
      I:   begin c.alu_op = 2'b10; c.rw = 1'b1; c.asrc = 1'b1; end
      LD:  begin c.rw = 1'b1; c.asrc = 1'b1; c.m2r = 1'b1; c.mr = 1'b1; end
      ST:  begin c.asrc = 1'b1; c.mw = 1'b1; end
      BR:  c.alu_op = 2'b01;
      JR:  begin c.rw = 1'b1; c.asrc = 1'b1; end
      LUI: begin c.rw = 1'b1; c.asrc = 1'b1; end
      default: c.rw = 1'b1;
    endcase
    return c;
  endfunction

  function automatic in_t rand_in();
    logic [6:0] ops [8];
    in_t c;
    ops = '{R, I, LD, ST, BR, JR, LUI, JAL};
    c = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    c.valid = ($urandom_range(0, 4) != 0);
    return c;
  endfunction

  function automatic ex_t zero_ex();
    ex_t z;
    z = '{valid: 1'b0, alu_op: 2'b00, default: '0};
    return z;
  endfunction

  // A load in EX whose destination is a register the ID instruction actually reads.
  function automatic logic model_stall(ex_t s, in_t c, logic fl);
    logic reads1, reads2;
    reads1 = c.op inside {R, I, LD, ST, BR, JR};
    reads2 = c.op inside {R, ST, BR};
    return c.valid && s.valid && s.mr && (s.rd != 5'd0) && !fl &&
           ((reads1 && c.rs1 == s.rd) || (reads2 && c.rs2 == s.rd));
  endfunction

  function automatic ex_t model_next(ex_t s, in_t c, logic rst, logic fl, logic hd);
    ex_t n;
    logic st;
    st = model_stall(s, c, fl);
    if (rst) return zero_ex();
    if (hd) return s;
    if (fl || st) begin
      n = zero_ex();
      n.cnt = s.cnt + (st ? 32'd1 : 32'd0);
      return n;
    end
    n = '{valid: c.valid, alu_op: 2'b00, rs1: c.rs1, rs2: c.rs2, rd: c.rd, d1: c.d1, d2: c.d2,
          imm: c.imm, pc: c.pc, f3: c.f3, f7: c.f7, cnt: s.cnt, default: '0};
    if (c.valid) begin
      n.alu_op = c.alu_op; n.rw = c.rw; n.asrc = c.asrc;
      n.m2r = c.m2r; n.mr = c.mr; n.mw = c.mw;
    end
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("ex_valid", 32'(ex_valid), 32'(m.valid));
    chk("ex_alu_op", 32'(ex_alu_op), 32'(m.alu_op));
    chk("ex_reg_write_en", 32'(ex_reg_write_en), 32'(m.rw));
    chk("ex_alu_src", 32'(ex_alu_src), 32'(m.asrc));
    chk("ex_mem_to_reg_en", 32'(ex_mem_to_reg_en), 32'(m.m2r));
    chk("ex_mem_read_en", 32'(ex_mem_read_en), 32'(m.mr));
    chk("ex_mem_write_en", 32'(ex_mem_write_en), 32'(m.mw));
    chk("ex_rs1", 32'(ex_rs1), 32'(m.rs1));
    chk("ex_rs2", 32'(ex_rs2), 32'(m.rs2));
    chk("ex_rd", 32'(ex_rd), 32'(m.rd));
    chk("ex_rs1_data", ex_rs1_data, m.d1);
    chk("ex_rs2_data", ex_rs2_data, m.d2);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_funct3", 32'(ex_funct3), 32'(m.f3));
    chk("ex_funct7_b5", 32'(ex_funct7_b5), 32'(m.f7));
    chk("bubble_count", bubble_count, m.cnt);
  endtask

  task automatic drive(in_t c, logic r, logic f, logic h);
    cur = c; reset = r; flush = f; ex_hold = h;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    chk("hazard_stall", 32'(hazard_stall), 32'(model_stall(m, cur, flush)));
    nxt = model_next(m, cur, reset, flush, ex_hold);
    @(posedge clk);
    #1;
    m = nxt;
    check_all();
    @(negedge clk);
  endtask

  task automatic lit_stall(logic exp);
    #1;
    chk("lit_hazard_stall", 32'(hazard_stall), 32'(exp));
  endtask

  initial begin
    drive(mk(R, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    m = zero_ex();
    step();
    chk("lit_reset_valid", 32'(ex_valid), 32'd0);
    chk("lit_reset_rw", 32'(ex_reg_write_en), 32'd0);
    chk("lit_reset_count", bubble_count, 32'd0);

    drive(mk(R, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0); step();
    chk("lit_rtype_rw", 32'(ex_reg_write_en), 32'd1);
    chk("lit_rtype_aluop", 32'(ex_alu_op), 32'd2);

    // Load-use on rs1.
    drive(mk(LD, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0, 1'b0); step();
    drive(mk(R, 5'd6, 5'd5, 5'd1), 1'b0, 1'b0, 1'b0); lit_stall(1'b1); step();
    chk("lit_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lit_count_1", bubble_count, 32'd1);
    lit_stall(1'b0); step();
    chk("lit_add_captured", 32'(ex_rd), 32'd6);

    // No false hazards: x0 destination, unused rs2 field.
    drive(mk(LD, 5'd0, 5'd1, 5'd0), 1'b0, 1'b0, 1'b0); step();
    drive(mk(R, 5'd6, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0); lit_stall(1'b0); step();
    drive(mk(LD, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0, 1'b0); step();
    drive(mk(I, 5'd7, 5'd2, 5'd5), 1'b0, 1'b0, 1'b0); lit_stall(1'b0); step();

    // Flush of a store, then flush racing a load-use.
    drive(mk(ST, 5'd0, 5'd2, 5'd3), 1'b0, 1'b1, 1'b0); step();
    chk("lit_flush_valid", 32'(ex_valid), 32'd0);
    chk("lit_flush_mw", 32'(ex_mem_write_en), 32'd0);
    drive(mk(LD, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0, 1'b0); step();
    drive(mk(R, 5'd6, 5'd5, 5'd1), 1'b0, 1'b1, 1'b0); lit_stall(1'b0); step();
    chk("lit_flush_count", bubble_count, 32'd1);

    // Hold for three cycles while ID keeps changing.
    drive(mk(R, 5'd9, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0); step();
    for (int k = 0; k < 3; k++) begin
      drive(mk(I, 5'(10 + k), 5'd3, 5'd0), 1'b0, 1'b0, 1'b1); step();
      chk("lit_hold_rd", 32'(ex_rd), 32'd9);
    end
    drive(mk(R, 5'd12, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0); step();
    chk("lit_release_rd", 32'(ex_rd), 32'd12);

    // Store data depends on a load.
    drive(mk(LD, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0, 1'b0); step();
    drive(mk(ST, 5'd0, 5'd2, 5'd5), 1'b0, 1'b0, 1'b0); lit_stall(1'b1); step();
    chk("lit_count_2", bubble_count, 32'd2);
    lit_stall(1'b0); step();
    chk("lit_store_mw", 32'(ex_mem_write_en), 32'd1);

    // Chained dependent loads stall once per pair.
    drive(mk(LD, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0, 1'b0); step();
    drive(mk(LD, 5'd6, 5'd5, 5'd0), 1'b0, 1'b0, 1'b0); lit_stall(1'b1); step();
    step();
    drive(mk(R, 5'd7, 5'd6, 5'd1), 1'b0, 1'b0, 1'b0); lit_stall(1'b1); step();
    chk("lit_count_4", bubble_count, 32'd4);

    // Reset asserted while a stall is pending.
    step();
    drive(mk(LD, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0, 1'b0); step();
    drive(mk(R, 5'd6, 5'd5, 5'd1), 1'b1, 1'b0, 1'b0); lit_stall(1'b1); step();
    chk("lit_reset_stall_count", bubble_count, 32'd0);
    chk("lit_reset_stall_valid", 32'(ex_valid), 32'd0);

    for (int k = 0; k < 3000; k++) begin
      drive(rand_in(), ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 6) == 0));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage sitting directly downstream of the decode control unit in the 5-stage RV32I pipeline.
- Registers the decoded control bundle (alu_op, reg_write_en, alu_src, mem_to_reg_en, mem_read_en, mem_write_en) together with operands, immediate, register indices and PC, and presents them to EX.
- Contains load-use hazard detection: stalls IF/ID and injects a bubble.
- Honours flush from branch resolution and hold from a downstream memory stall.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register index width.
- CNTW, 32, width of the bubble/stall performance counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_opcode  in  7  instruction opcode, used for operand-use decode
- id_alu_op  in  2  from control unit
- id_reg_write_en, id_alu_src, id_mem_to_reg_en, id_mem_read_en, id_mem_write_en  in  1 each  from control unit
- id_rs1, id_rs2, id_rd  in  REGW  register indices
- id_rs1_data, id_rs2_data, id_imm, id_pc  in  XLEN  operands, immediate, PC
- id_funct3  in  3 ; id_funct7_b5  in  1  ALU-control inputs
- flush  in  1  branch/jump taken in EX; kill the younger instruction
- ex_hold  in  1  downstream stall; freeze this stage
- hazard_stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  ; ex_* registered copies of every id_* input except id_valid and id_opcode, same widths
- bubble_count  out  CNTW  number of bubbles inserted since reset

Behaviour:
- All outputs update on rising clk; latency ID to EX is 1 cycle.
- Reset (sync, active-high):
  - ex_valid=0, all ex_* control bits=0, ex_alu_op=2'b00.
  - ex_* data/index/PC=0.
  - bubble_count=0.
  - Reset wins over all other inputs, including mid-stall.
- Operand use, decoded from id_opcode:
  - uses_rs1 for 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - uses_rs2 for 0110011, 0100011, 1100011.
  - All other opcodes use neither.
- hazard_stall (combinational) = id_valid & ex_valid & ex_mem_read_en & (ex_rd!=0) & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)) & ~flush.
- Next-state priority per cycle:
  1. reset
  2. ex_hold: all ex_* hold; counter holds; hazard_stall still evaluated from held values.
  3. flush: load a bubble.
  4. hazard_stall: load a bubble, bubble_count += 1.
  5. normal: capture all id_* fields, ex_valid=id_valid.
- Bubble definition:
  - ex_valid=0; reg_write_en, mem_read_en, mem_write_en, mem_to_reg_en, alu_src=0; alu_op=00.
  - Data fields are don't-care; zero them for waveform clarity.
- When id_valid=0 in the normal case, control bits are forced to 0 regardless of the id_* values, so no side effects occur.
- A load-use stall lasts exactly 1 cycle, because the bubble clears ex_mem_read_en.
- Back-to-back loads with a dependency: stall again for each dependent pair.
- flush together with hazard: flush wins, no stall, and the counter does not increment.
- bubble_count wraps modulo 2^CNTW.
- rd==x0 never causes a stall.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR.
  - ALU_OP_ADD=00, ALU_OP_BR=01, ALU_OP_FUNC=10.
  - ctrl_t packed struct of the six control fields, with a CTRL_NOP constant.
- One natural sub-module: hazard_detect (combinational operand-use decode plus compare). The pipeline register stays in id_ex_stage.

Test Plan:
- Reset: assert reset for 2 cycles with id_valid=1 and R-type inputs -> ex_valid=0, all control 0, bubble_count=0; after release, the next edge captures the R-type (ex_reg_write_en=1, ex_alu_op=10).
- Load-use: lw x5 in EX, id add x6,x5,x1 (id_rs1=5) -> hazard_stall=1 for one cycle, EX gets a bubble, bubble_count=1; next cycle the add is captured with stall=0.
- No false hazard:
  - lw x0 followed by use of x0 -> no stall.
  - lw x5 followed by addi x7,x2,5 with id_rs2 field=5 (I-type, rs2 not used) -> no stall.
- Flush: flush=1 with a valid sw in ID -> ex_valid=0, ex_mem_write_en=0; flush plus a simultaneous load-use condition -> hazard_stall=0 and bubble_count unchanged.
- Hold: ex_hold=1 for 3 cycles while ID changes -> ex_* stable across all 3 cycles; on release, the current ID contents are captured.
- Store after load: lw x5 then sw x5,0(x2) (rs2=5) -> 1-cycle stall; bubble_count increments from 1 to 2.
